crc_multi_read: RTL and testbench

- Parametrised successor to the single-lane CRC7 response checker.
- Computes CRC-N (CRC7 for the CMD line, CRC16 for the DAT lines) over 1..8 parallel serial lanes in the SD clock domain.
- After the payload, it receives the transmitted CRC bits and compares them on the fly, reporting a per-lane error with a done pulse.
- Sits between the CMD/DAT line samplers and the response/data read FSMs.

---
 rtl/crc_read_pkg.sv | 17 +
 rtl/crc_lane.sv | 57 +++++
 rtl/crc_multi_read.sv | 142 ++++++++++++++
 tb/tb_crc_multi_read.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_read_pkg.sv
// Shared types and constants for the multi-lane CRC read checker.
package crc_read_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CALC,
        ST_CHECK,
        ST_DONE
    } crc_read_state_e;

    localparam int         CRC7_W     = 7;
    localparam int         CRC16_W    = 16;
    localparam logic [6:0]  CRC7_POLY  = 7'h09;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/crc_lane.sv
// One serial lane: CRC_W-bit LFSR plus a mismatch accumulator that compares
// the received CRC bits (MSB first) against the frozen LFSR contents.
module crc_lane
    import crc_read_pkg::*;
#(
    parameter int               CRC_W = CRC16_W,
    parameter logic [CRC_W-1:0] POLY  = CRC16_POLY[CRC_W-1:0],
    parameter int               CNT_W = $clog2(CRC_W)
) (
    input  logic             sd_clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             chk_i,
    input  logic [CNT_W-1:0] idx_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(CRC_W - 1);

    logic [CRC_W-1:0] crc_q, crc_d;
    logic             err_q, err_d;
    logic             fb;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        crc_d = crc_q;
        err_d = err_q;
        fb    = bit_i ^ crc_q[CRC_W-1];
        if (clr_i) begin
            crc_d = '0;
            err_d = 1'b0;
        end else if (shift_i) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end else if (chk_i) begin
            err_d = err_q | (bit_i ^ crc_q[TOP_IDX - idx_i]);
        end
    end

    always_ff @(posedge sd_clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            crc_q <= '0;
            err_q <= 1'b0;
        end else begin
            crc_q <= crc_d;
            err_q <= err_d;
        end
    end

    assign crc_o = crc_q;
    assign err_o = err_q;

endmodule

// File: rtl/crc_multi_read.sv
// Multi-lane CRC read checker: FSM, CHECK-phase bit counter and result registers.
// Optional macro CRC_MULTI_READ_STICKY_ERR_EN makes crc_err_o accumulate across runs.
module crc_multi_read
    import crc_read_pkg::*;
#(
    parameter int          CRC_W = CRC16_W,
    parameter logic [15:0] POLY  = CRC16_POLY,
    parameter int          LANES = 4,
    parameter int          CHECK = 1
) (
    input  logic                   sd_clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   end_data_i,
    input  logic                   abort_i,
    input  logic [LANES-1:0]       dat_ser_i,
    input  logic                   clr_err_i,
    output logic                   busy_o,
    output logic [LANES*CRC_W-1:0] crc_o,
    output logic                   crc_valid_o,
    output logic                   check_done_o,
    output logic [LANES-1:0]       crc_err_o
);

    localparam int               CNT_W    = $clog2(CRC_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);
    localparam logic             CHECK_EN = (CHECK != 0);

    crc_read_state_e        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic [LANES-1:0]       err_q, err_d;
    logic                   lane_clr, lane_shift, lane_chk, done;
    logic [LANES-1:0]       lane_err, run_err;
    logic [LANES*CRC_W-1:0] lane_crc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        lane_clr   = 1'b0;
        lane_shift = 1'b0;
        lane_chk   = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_CLEAR;
            ST_CLEAR: begin
                lane_clr = 1'b1;
                valid_d  = 1'b0;
                cnt_d    = '0;
                state_d  = ST_CALC;
            end
            ST_CALC: begin
                lane_shift = 1'b1;
                if (end_data_i) begin
                    cnt_d   = '0;
                    state_d = CHECK_EN ? ST_CHECK : ST_DONE;
                    valid_d = !CHECK_EN;
                end
            end
            ST_CHECK: begin
                lane_chk = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over everything: drop the run without a done pulse.
        if (abort_i && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            valid_d    = 1'b0;
            lane_shift = 1'b0;
            lane_chk   = 1'b0;
            done       = 1'b0;
        end
    end

    assign run_err = CHECK_EN ? lane_err : '0;

`ifdef CRC_MULTI_READ_STICKY_ERR_EN
    always_comb begin
        err_d = clr_err_i ? '0 : err_q;
        if (done) err_d = err_d | run_err;
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err_i;

    always_comb begin
        err_d = err_q;
        if (done) err_d = run_err;
    end
`endif

    always_ff @(posedge sd_clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        crc_lane #(
            .CRC_W (CRC_W),
            .POLY  (POLY[CRC_W-1:0]),
            .CNT_W (CNT_W)
        ) u_lane (
            .sd_clk_i (sd_clk_i),
            .rst_i    (rst_i),
            .clr_i    (lane_clr),
            .shift_i  (lane_shift),
            .chk_i    (lane_chk),
            .idx_i    (cnt_q),
            .bit_i    (dat_ser_i[k]),
            .crc_o    (lane_crc[k*CRC_W +: CRC_W]),
            .err_o    (lane_err[k])
        );
    end

    // Hold crc_o at zero outside a valid result so downstream logic stays quiet.
    assign crc_o        = valid_q ? lane_crc : '0;
    assign busy_o       = (state_q != ST_IDLE);
    assign crc_valid_o  = valid_q;
    assign check_done_o = done;
    assign crc_err_o    = err_q;

endmodule

// File: tb/tb_crc_multi_read.sv
// Bench for crc_multi_read: a CRC7/1-lane and a CRC16/4-lane instance checked
// against a polynomial long-division reference model.
module tb_crc_multi_read;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, clr = 1'b0;
    logic        st7 = 0, en7 = 0, ab7 = 0, dat7 = 0;
    logic        st16 = 0, en16 = 0, ab16 = 0;
    logic [3:0]  dat16 = '0;
    logic        busy7, valid7, done7, err7;
    logic [6:0]  crc7;
    logic        busy16, valid16, done16;
    logic [63:0] crc16;
    logic [3:0]  err16;

    crc_multi_read #(.CRC_W(7), .POLY(16'h0009), .LANES(1), .CHECK(1)) u_crc7 (
        .sd_clk_i(clk), .rst_i(rst), .start_i(st7), .end_data_i(en7), .abort_i(ab7),
        .dat_ser_i(dat7), .clr_err_i(clr), .busy_o(busy7), .crc_o(crc7),
        .crc_valid_o(valid7), .check_done_o(done7), .crc_err_o(err7));

    crc_multi_read #(.CRC_W(16), .POLY(16'h1021), .LANES(4), .CHECK(1)) u_crc16 (
        .sd_clk_i(clk), .rst_i(rst), .start_i(st16), .end_data_i(en16), .abort_i(ab16),
        .dat_ser_i(dat16), .clr_err_i(clr), .busy_o(busy16), .crc_o(crc16),
        .crc_valid_o(valid16), .check_done_o(done16), .crc_err_o(err16));

    int total = 0, bad = 0;
    int nd7 = 0, nd16 = 0;
    logic [3:0]  pay [4096];
    int          plen;
    logic [15:0] tx [4];

    always @(negedge clk) begin
        if (done7)  nd7++;
        if (done16) nd16++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] o_crc(input int sel);
        if (sel != 0) return crc16;
        return {57'b0, crc7};
    endfunction
    function automatic logic [3:0] o_err(input int sel);
        if (sel != 0) return err16;
        return {3'b0, err7};
    endfunction
    function automatic logic o_busy(input int sel);  return (sel != 0) ? busy16  : busy7;  endfunction
    function automatic logic o_valid(input int sel); return (sel != 0) ? valid16 : valid7; endfunction
    function automatic logic o_done(input int sel);  return (sel != 0) ? done16  : done7;  endfunction
    function automatic int   o_nd(input int sel);    return (sel != 0) ? nd16    : nd7;    endfunction

    task automatic drive(input int sel, input logic st, input logic en, input logic ab,
                         input logic [3:0] d);
        if (sel != 0) begin
            st16 = st; en16 = en; ab16 = ab; dat16 = d;
        end else begin
            st7 = st; en7 = en; ab7 = ab; dat7 = d[0];
        end
    endtask

    // Remainder of M(x)*x^w divided by x^w + poly(x), by long division.
    function automatic logic [15:0] crc_ref(input int lane, input int w, input logic [15:0] poly);
        bit m[$];
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < plen; i++) m.push_back(pay[i][lane]);
        for (int i = 0; i < w; i++) m.push_back(1'b0);
        for (int i = 0; i < plen; i++) begin
            if (m[i]) begin
                m[i] = 1'b0;
                for (int j = 1; j <= w; j++) m[i+j] = m[i+j] ^ poly[w-j];
            end
        end
        for (int j = 0; j < w; j++) r[w-1-j] = m[plen+j];
        return r;
    endfunction

    function automatic int wid(input int sel);   return (sel != 0) ? 16 : 7; endfunction
    function automatic logic [15:0] pol(input int sel); return (sel != 0) ? 16'h1021 : 16'h0009; endfunction
    function automatic int nlanes(input int sel); return (sel != 0) ? 4 : 1; endfunction

    task automatic set_msg40(input logic [39:0] msg, input logic [15:0] crc_bits);
        plen = 40;
        for (int i = 0; i < 40; i++) pay[i] = {3'b0, msg[39-i]};
        tx[0] = crc_bits;
    endtask

    // Random payload; each lane's transmitted CRC is correct or has one bit flipped.
    task automatic set_random(input int sel, input int n);
        logic [15:0] r;
        int w;
        w = wid(sel);
        plen = n;
        for (int i = 0; i < n; i++) pay[i] = 4'($urandom());
        for (int k = 0; k < nlanes(sel); k++) begin
            r = crc_ref(k, w, pol(sel));
            if ($urandom_range(0, 2) == 0) r[$urandom_range(0, w - 1)] ^= 1'b1;
            tx[k] = r;
        end
    endtask

    // kind: 0 complete run, 1 abort at step 'at', 2 reset at step 'at'.
    task automatic run(input int sel, input int kind, input int at, input string tag);
        int          w, nd;
        logic [63:0] exp_crc;
        logic [3:0]  exp_err, err_before, d;
        logic [15:0] r;
        logic        en;
        w = wid(sel);
        exp_crc = '0;
        exp_err = '0;
        err_before = o_err(sel);
        nd = o_nd(sel);
        for (int k = 0; k < nlanes(sel); k++) begin
            r = crc_ref(k, w, pol(sel));
            exp_crc[k*16 +: 16] = r;
            exp_err[k] = ((tx[k] & 16'((1 << w) - 1)) != r);
        end
        drive(sel, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        // end_data_i during CLEAR must be ignored.
        drive(sel, 1'b0, 1'b1, 1'b0, 4'h0);
        tick();
        for (int i = 0; i < plen + w; i++) begin
            if (i < plen) d = pay[i];
            else for (int k = 0; k < 4; k++) d[k] = tx[k][w-1-(i-plen)];
            en = (i == plen - 1);
            if (kind != 0 && i == at) begin
                if (kind == 1) drive(sel, 1'b0, en, 1'b1, d);
                else begin
                    rst = 1'b1;
                    drive(sel, 1'b0, en, 1'b0, d);
                end
                tick();
                rst = 1'b0;
                drive(sel, 1'b0, 1'b0, 1'b0, 4'h0);
                check({tag, "_busy"}, 64'(o_busy(sel)), 64'd0);
                check({tag, "_valid"}, 64'(o_valid(sel)), 64'd0);
                check({tag, "_crc"}, o_crc(sel), 64'd0);
                check({tag, "_err"}, 64'(o_err(sel)), (kind == 1) ? 64'(err_before) : 64'd0);
                tick();
                check({tag, "_nodone"}, 64'(o_nd(sel)), 64'(nd));
                return;
            end
            // start_i pulsed mid-CALC must be ignored.
            drive(sel, (i == 0), en, 1'b0, d);
            tick();
        end
        drive(sel, 1'b0, 1'b0, 1'b0, 4'h0);
        check({tag, "_done"}, 64'(o_done(sel)), 64'd1);
        check({tag, "_valid"}, 64'(o_valid(sel)), 64'd1);
        check({tag, "_crc"}, o_crc(sel), exp_crc);
        tick();
        check({tag, "_idle"}, 64'(o_busy(sel)), 64'd0);
        check({tag, "_ndone"}, 64'(o_nd(sel)), 64'(nd + 1));
`ifdef CRC_MULTI_READ_STICKY_ERR_EN
        check({tag, "_err"}, 64'(o_err(sel)), 64'(err_before | exp_err));
`else
        check({tag, "_err"}, 64'(o_err(sel)), 64'(exp_err));
`endif
        check({tag, "_crc_hold"}, o_crc(sel), exp_crc);
    endtask

    logic [3:0] prev_err;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            check("rst_busy", 64'(o_busy(s)), 64'd0);
            check("rst_crc", o_crc(s), 64'd0);
            check("rst_err", 64'(o_err(s)), 64'd0);
            check("rst_valid", 64'(o_valid(s)), 64'd0);
            check("rst_done", 64'(o_done(s)), 64'd0);
        end

        set_msg40(40'h40_0000_0000, 16'h004A);
        run(0, 0, 0, "cmd0");
        check("cmd0_const", 64'(crc7), 64'h4A);
        set_msg40(40'h51_0000_0000, 16'h002A);
        run(0, 0, 0, "cmd17_ok");
        check("cmd17_ok_flag", 64'(err7), 64'd0);
        set_msg40(40'h51_0000_0000, 16'h002B);
        run(0, 0, 0, "cmd17_bad");
        check("cmd17_bad_flag", 64'(err7), 64'd1);

        plen = 4096;
        for (int i = 0; i < 4096; i++) pay[i] = 4'hF;
        tx[0] = 16'h7FA1; tx[1] = 16'h7FA1; tx[2] = 16'h7FA1; tx[3] = 16'h7FA0;
        run(1, 0, 0, "ones4096");
        check("ones4096_const", crc16, {4{16'h7FA1}});
        check("ones4096_errv", 64'(err16), 64'b1000);

        prev_err = err16;
        clr = 1'b1;
        tick();
        clr = 1'b0;
`ifdef CRC_MULTI_READ_STICKY_ERR_EN
        check("clr_err", 64'(err16), 64'd0);
`else
        check("clr_err", 64'(err16), 64'(prev_err));
`endif

        // Erroring run then clean run: sticky build keeps the flag.
        set_random(1, 20);
        tx[1] ^= 16'h0100;
        run(1, 0, 0, "err_run");
        prev_err = err16;
        set_random(1, 20);
        for (int k = 0; k < 4; k++) tx[k] = crc_ref(k, 16, 16'h1021);
        run(1, 0, 0, "clean_run");
`ifdef CRC_MULTI_READ_STICKY_ERR_EN
        check("sticky_keep", 64'(err16), 64'(prev_err));
`else
        check("sticky_keep", 64'(err16), 64'd0);
`endif

        set_random(1, 20);
        run(1, 1, 5, "abort_calc16");
        run(1, 1, 23, "abort_check16");
        run(1, 0, 0, "after_abort16");
        set_random(0, 30);
        run(0, 1, 33, "abort_check7");
        run(0, 0, 0, "after_abort7");

        set_random(1, 12);
        run(1, 2, 18, "rst_check16");
        run(1, 0, 0, "after_rst16");

        set_random(0, 1);
        run(0, 0, 0, "len1_7");
        set_random(1, 1);
        run(1, 0, 0, "len1_16");

        for (int r = 0; r < 6; r++) begin
            set_random(1, $urandom_range(1, 80));
            run(1, 0, 0, "rand16");
            set_random(0, $urandom_range(1, 80));
            run(0, 0, 0, "rand7");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
